axis_bram_peer: RTL

Traffic peer for the AXIS/BRAM bridge. It sits at the far end of both streams: it transmits a counting-pattern frame into the bridge's stream slave, pulses the bridge's read-back control, then receives the read-back frame from the bridge's stream master. It checks every received word and `tlast` against the expected pattern and reports pass/fail and an error count. Used in loopback benches and on-board bring-up.

---
 rtl/axis_bram_peer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/axis_bram_peer.sv
// Traffic peer for the AXIS/BRAM bridge: sends a counting frame, requests read-back, checks the echo.
// Optional LFSR-driven stream throttling is enabled by defining AXIS_BRAM_PEER_BACKPRESSURE_EN.
module axis_bram_peer #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_LEN_WIDTH  = 12,
  parameter int C_FLUSH_GAP  = 8,
  parameter int C_TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [C_LEN_WIDTH-1:0]    len,
  input  logic [C_DATA_WIDTH-1:0]   base,
  output logic                      rb_start,
  output logic [C_LEN_WIDTH-1:0]    rb_index,
  output logic [C_LEN_WIDTH-1:0]    rb_length,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [15:0]               err_count,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                      m_axis_tlast,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                      s_axis_tlast
);
  localparam int GW = $clog2(C_FLUSH_GAP + 1);
  localparam int TW = $clog2(C_TIMEOUT + 1);
  localparam logic [C_LEN_WIDTH-1:0] LEN_ONE = 1;
  localparam logic [GW-1:0]          GAP_ONE = 1;
  localparam logic [TW-1:0]          WD_ONE  = 1;

  typedef enum logic [1:0] {IDLE, TX, GAP, RX} state_t;
  state_t state, state_nx;

  logic [C_LEN_WIDTH-1:0]  len_q, tx_cnt, rx_cnt;
  logic [C_DATA_WIDTH-1:0] base_q, rx_exp;
  logic [GW-1:0]           gap_cnt;
  logic [TW-1:0]           wd_cnt;
  logic tx_hold, tx_throttle, rx_throttle;
  logic tx_hs, rx_hs, tx_last, rx_last, start_ok, gap_end, wd_fire;
  logic data_bad, last_bad;
  logic [16:0] err_sum;
  logic [15:0] err_nx;
  logic unused_tstrb;

`ifdef AXIS_BRAM_PEER_BACKPRESSURE_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= 8'hA5;
    else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign tx_throttle = lfsr[0];
  assign rx_throttle = lfsr[1];
`else
  assign tx_throttle = 1'b0;
  assign rx_throttle = 1'b0;
`endif

  assign unused_tstrb = ^s_axis_tstrb;

  // A presented beat stays up through throttling until it is accepted.
  assign m_axis_tvalid = (state == TX) && (tx_hold || !tx_throttle);
  assign m_axis_tdata  = base_q + C_DATA_WIDTH'(tx_cnt);
  assign m_axis_tlast  = tx_last;
  assign m_axis_tstrb  = '1;
  assign s_axis_tready = (state == RX) && !rx_throttle;
  assign rb_index      = '0;
  assign rb_length     = len_q;
  assign busy          = (state != IDLE);

  assign tx_hs    = m_axis_tvalid && m_axis_tready;
  assign rx_hs    = s_axis_tvalid && s_axis_tready;
  assign tx_last  = (tx_cnt == len_q - LEN_ONE);
  assign rx_last  = (rx_cnt == len_q - LEN_ONE);
  assign start_ok = start && !done;
  assign gap_end  = (gap_cnt == GW'(C_FLUSH_GAP - 1));
  assign wd_fire  = (wd_cnt == TW'(C_TIMEOUT - 1)) && !rx_hs;

  assign rx_exp   = base_q + C_DATA_WIDTH'(rx_cnt);
  assign data_bad = (s_axis_tdata != rx_exp);
  assign last_bad = (s_axis_tlast != rx_last);
  assign err_sum  = {1'b0, err_count} + {16'd0, data_bad} + {16'd0, last_bad};
  assign err_nx   = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok && len != '0) state_nx = TX;
      TX:      if (tx_hs && tx_last) state_nx = GAP;
      GAP:     if (gap_end) state_nx = RX;
      RX:      if ((rx_hs && rx_last) || wd_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tx_hold <= 1'b0;
    else          tx_hold <= m_axis_tvalid && !m_axis_tready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q     <= '0;
      base_q    <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      gap_cnt   <= '0;
      wd_cnt    <= '0;
      err_count <= '0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      done      <= 1'b0;
      rb_start  <= 1'b0;
    end else begin
      done     <= 1'b0;
      rb_start <= 1'b0;
      case (state)
        IDLE: if (start_ok) begin
          err_count <= '0;
          timeout   <= 1'b0;
          if (len == '0) begin
            done <= 1'b1;
            pass <= 1'b1;
          end else begin
            pass    <= 1'b0;
            len_q   <= len;
            base_q  <= base;
            tx_cnt  <= '0;
            rx_cnt  <= '0;
            gap_cnt <= '0;
          end
        end
        TX: if (tx_hs) tx_cnt <= tx_cnt + LEN_ONE;
        GAP: begin
          gap_cnt <= gap_cnt + GAP_ONE;
          if (gap_end) begin
            rb_start <= 1'b1;
            wd_cnt   <= '0;
          end
        end
        RX: begin
          if (rx_hs) begin
            err_count <= err_nx;
            rx_cnt    <= rx_cnt + LEN_ONE;
            wd_cnt    <= '0;
            if (rx_last) begin
              done <= 1'b1;
              pass <= (err_nx == 16'd0);
            end
          end else if (wd_fire) begin
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_ONE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
